// File: rtl/byte_serial_adder.sv
// byte_serial_adder: serialises wide additions one byte pair per cycle,
// least-significant byte first. Each byte pair is added with the carry held
// from the previous byte. Sum bytes leave through a single registered output
// stage with packet framing, the final carry and a length-overflow flag.
module byte_serial_adder #(
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sum_byte,
    output logic       out_last,
    output logic       carry_out,
    output logic       len_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Index of the last byte a packet may carry before it is force-terminated.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BYTES - 1);

    // 8-bit carry-select adder with carry-in: the upper nibble is computed for
    // both possible nibble carries and the lower nibble's carry picks one.
    function automatic logic [8:0] cs_add8(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic       ci);
        logic [4:0] lo;
        logic [4:0] hi0;
        logic [4:0] hi1;
        logic [4:0] hi;
        lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, ci};
        hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1 = hi0 + 5'd1;
        hi  = lo[4] ? hi1 : hi0;
        return {hi, lo[3:0]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             carry_r;
    logic             carry_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             accept_s;
    logic             overflow_s;
    logic             end_s;
    logic [8:0]       sum9_s;

    // Input can be taken whenever the output register is empty or draining.
    assign in_ready   = !out_valid || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign sum9_s     = cs_add8(a_byte, b_byte, carry_r);
    // A non-last beat at the final legal index closes the packet by force.
    assign overflow_s = !in_last && (cnt_r == LAST_IDX);
    assign end_s      = in_last || overflow_s;

    // Next packet state, inter-byte carry and byte count; change only on acceptance.
    always_comb begin
        state_nxt_s = state_r;
        carry_nxt_s = carry_r;
        cnt_nxt_s   = cnt_r;
        if (accept_s) begin
            if (end_s) begin
                state_nxt_s = IDLE;
                carry_nxt_s = 1'b0;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
                state_nxt_s = ACTIVE;
                carry_nxt_s = sum9_s[8];
                cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
        end else begin
            state_nxt_s = state_r;
            carry_nxt_s = carry_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Packet state, carry and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            carry_r <= carry_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output register: load on acceptance, empty when taken, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum_byte  <= 8'h00;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            len_err   <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            sum_byte  <= sum9_s[7:0];
            out_last  <= end_s;
            carry_out <= end_s ? sum9_s[8] : 1'b0;
            len_err   <= overflow_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            sum_byte  <= sum_byte;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            out_valid <= out_valid;
            sum_byte  <= sum_byte;
            out_last  <= out_last;
            carry_out <= carry_out;
            len_err   <= len_err;
        end
    end

endmodule
